bank_mapper: RTL and testbench

Parametrised successor to the cartridge page mapper. It snoops Z80 memory writes and holds the slot page registers and the cart-RAM control register. It translates a 16-bit cartridge address into a flash byte address, or into a cart-RAM select/address.
- Supports Sega and Codemasters mapper modes.
- Supports ROM-size page masking.
- Sits between the MMU's cart port and the ROM/flash and cart-RAM memories.

---
 rtl/sggoc_pkg.sv | 34 +++
 rtl/mapper_regs.sv | 55 +++++
 rtl/bank_mapper.sv | 69 ++++++
 tb/tb_bank_mapper.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sggoc_pkg.sv
// rtl/sggoc_pkg.sv - shared constants and types for the cartridge bank mapper
package sggoc_pkg;

    localparam logic [15:0] MAP_CTRL = 16'hFFFC;
    localparam logic [15:0] MAP_P0   = 16'hFFFD;
    localparam logic [15:0] MAP_P1   = 16'hFFFE;
    localparam logic [15:0] MAP_P2   = 16'hFFFF;

    localparam logic [15:0] CM_P0 = 16'h0000;
    localparam logic [15:0] CM_P1 = 16'h4000;
    localparam logic [15:0] CM_P2 = 16'h8000;

    localparam logic MODE_SEGA = 1'b0;
    localparam logic MODE_CM   = 1'b1;

    localparam logic [7:0] RST_PAGE0 = 8'd0;
    localparam logic [7:0] RST_PAGE1 = 8'd1;
    localparam logic [7:0] RST_PAGE2 = 8'd2;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_e;

    // Low-bit mask for a ROM of 2^log2 pages; log2 is at most 8.
    function automatic logic [7:0] page_mask(input int log2);
        logic [8:0] m;
        m = (9'd1 << log2) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/mapper_regs.sv
// rtl/mapper_regs.sv - mode latch, write-edge detect and mapper register file
module mapper_regs
    import sggoc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  di,
    output logic        mode_q,
    output logic [7:0]  page0,
    output logic [7:0]  page1,
    output logic [7:0]  page2,
    output logic [7:0]  ctrl
);

    logic wr_q;
    logic wr_edge;

    assign wr_edge = wr & ~wr_q;

    // wr_q resets high so a strobe still asserted at reset release is not a new write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= mode;
            wr_q   <= 1'b1;
            page0  <= RST_PAGE0;
            page1  <= RST_PAGE1;
            page2  <= RST_PAGE2;
            ctrl   <= 8'h00;
        end else begin
            wr_q <= wr;
            if (wr_edge) begin
                if (mode_q == MODE_SEGA) begin
                    case (addr)
                        MAP_CTRL: ctrl  <= di;
                        MAP_P0:   page0 <= di;
                        MAP_P1:   page1 <= di;
                        MAP_P2:   page2 <= di;
                        default:  ;
                    endcase
                end else begin
                    case (addr)
                        CM_P0:   page0 <= di;
                        CM_P1:   page1 <= di;
                        CM_P2:   page2 <= di;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/bank_mapper.sv
// rtl/bank_mapper.sv - cartridge address translation to flash bytes or cart RAM
module bank_mapper
    import sggoc_pkg::*;
#(
    parameter int FLASH_AW       = 22,
    parameter int ROM_PAGES_LOG2 = 8,
    parameter int CRAM_EN        = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                wr,
    input  logic [15:0]         addr,
    input  logic [7:0]          di,
    output logic                rom_sel,
    output logic [FLASH_AW-1:0] flash_addr,
    output logic                cram_sel,
    output logic                cram_we,
    output logic [14:0]         cram_addr,
    output logic [7:0]          page0,
    output logic [7:0]          page1,
    output logic [7:0]          page2,
    output logic [7:0]          ctrl
);

    localparam logic [7:0] PG_MASK = page_mask(ROM_PAGES_LOG2);

    logic        mode_q;
    slot_e       slot;
    logic [7:0]  pg_raw;
    logic [7:0]  pg_masked;
    logic [21:0] rom_off;

    mapper_regs u_regs (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .wr     (wr),
        .addr   (addr),
        .di     (di),
        .mode_q (mode_q),
        .page0  (page0),
        .page1  (page1),
        .page2  (page2),
        .ctrl   (ctrl)
    );

    // The first 1 KB stays on page 0 in Sega mode so the reset vectors never move.
    always_comb begin
        slot = slot_e'(addr[15:14]);
        case (slot)
            SLOT0:   pg_raw = page0;
            SLOT1:   pg_raw = page1;
            default: pg_raw = page2;
        endcase
        if (mode_q == MODE_SEGA && addr < 16'h0400)
            pg_raw = 8'h00;
    end

    assign pg_masked  = pg_raw & PG_MASK;
    assign rom_off    = {pg_masked, addr[13:0]};
    assign flash_addr = (slot == SLOT3) ? '0 : FLASH_AW'(rom_off);

    assign cram_sel  = (CRAM_EN != 0) && (mode_q == MODE_SEGA) && ctrl[3] && (slot == SLOT2);
    assign cram_we   = cram_sel & wr;
    assign cram_addr = (CRAM_EN != 0) ? {ctrl[2], addr[13:0]} : 15'h0000;
    assign rom_sel   = (slot != SLOT3) && !cram_sel;

endmodule

// File: tb/tb_bank_mapper.sv
// tb/tb_bank_mapper.sv - self-checking bench for bank_mapper
module tb_bank_mapper;

    logic        clk = 1'b0;
    logic        rst, mode, wr;
    logic [15:0] addr;
    logic [7:0]  di;

    logic        rom_sel, cram_sel, cram_we;
    logic [21:0] flash_addr;
    logic [14:0] cram_addr;
    logic [7:0]  page0, page1, page2, ctrl;

    logic        rom_sel4, cram_sel4, cram_we4;
    logic [17:0] flash_addr4;
    logic [14:0] cram_addr4;
    logic [7:0]  page04, page14, page24, ctrl4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bank_mapper dut (
        .clk(clk), .rst(rst), .mode(mode), .wr(wr), .addr(addr), .di(di),
        .rom_sel(rom_sel), .flash_addr(flash_addr), .cram_sel(cram_sel),
        .cram_we(cram_we), .cram_addr(cram_addr),
        .page0(page0), .page1(page1), .page2(page2), .ctrl(ctrl)
    );

    bank_mapper #(.FLASH_AW(18), .ROM_PAGES_LOG2(4), .CRAM_EN(0)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .wr(wr), .addr(addr), .di(di),
        .rom_sel(rom_sel4), .flash_addr(flash_addr4), .cram_sel(cram_sel4),
        .cram_we(cram_we4), .cram_addr(cram_addr4),
        .page0(page04), .page1(page14), .page2(page24), .ctrl(ctrl4)
    );

    typedef struct {
        bit          w;
        logic [15:0] waddr;
        logic [7:0]  wdata;
        logic [15:0] raddr;
        logic        rwr;
        logic        rom;
        logic [21:0] flash;
        logic        cram;
        logic        cwe;
        logic [14:0] caddr;
        logic [7:0]  p0, p1, p2, ctl;
        logic [17:0] flash4;
    } vec_t;

    typedef struct {
        string       name;
        logic        rom;
        logic [21:0] flash;
        logic        cram;
        logic        cwe;
        logic [14:0] caddr;
        logic [7:0]  p0, p1, p2, ctl;
        logic [17:0] flash4;
        logic        rom4;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic m, input logic w);
        rst  = 1'b1;
        mode = m;
        wr   = w;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic z80_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        wr = 1'b0;
        tick();
        addr = a;
        di   = d;
        wr   = 1'b1;
        repeat (hold) tick();
        wr = 1'b0;
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".rom_sel"},    32'(rom_sel),     32'(e.rom));
        chk({e.name, ".flash_addr"}, 32'(flash_addr),  32'(e.flash));
        chk({e.name, ".cram_sel"},   32'(cram_sel),    32'(e.cram));
        chk({e.name, ".cram_we"},    32'(cram_we),     32'(e.cwe));
        chk({e.name, ".cram_addr"},  32'(cram_addr),   32'(e.caddr));
        chk({e.name, ".page0"},      32'(page0),       32'(e.p0));
        chk({e.name, ".page1"},      32'(page1),       32'(e.p1));
        chk({e.name, ".page2"},      32'(page2),       32'(e.p2));
        chk({e.name, ".ctrl"},       32'(ctrl),        32'(e.ctl));
        chk({e.name, ".flash4"},     32'(flash_addr4), 32'(e.flash4));
        chk({e.name, ".rom_sel4"},   32'(rom_sel4),    32'(e.rom4));
        chk({e.name, ".cram_sel4"},  32'(cram_sel4),   32'd0);
        chk({e.name, ".cram_we4"},   32'(cram_we4),    32'd0);
        chk({e.name, ".cram_addr4"}, 32'(cram_addr4),  32'd0);
        chk({e.name, ".ctrl4"},      32'(ctrl4),       32'(e.ctl));
        chk({e.name, ".pages4"},     32'({page04[3:0], page14[3:0], page24[3:0]}),
            32'({e.p0[3:0], e.p1[3:0], e.p2[3:0]}));
    endtask

    initial begin
        vec_t v;
        exp_t e;

        //            w  waddr     wdata  raddr     rwr rom flash      cram cwe caddr     p0     p1     p2     ctl    flash4
        vecs[0]  = '{0, 16'h0000, 8'h00, 16'h8123, 0,  1, 22'h08123, 0, 0, 15'h0123, 8'h00, 8'h01, 8'h02, 8'h00, 18'h08123};
        vecs[1]  = '{0, 16'h0000, 8'h00, 16'h4010, 0,  1, 22'h04010, 0, 0, 15'h0010, 8'h00, 8'h01, 8'h02, 8'h00, 18'h04010};
        vecs[2]  = '{0, 16'h0000, 8'h00, 16'hC000, 0,  0, 22'h00000, 0, 0, 15'h0000, 8'h00, 8'h01, 8'h02, 8'h00, 18'h00000};
        vecs[3]  = '{1, 16'hFFFF, 8'h05, 16'h8123, 0,  1, 22'h14123, 0, 0, 15'h0123, 8'h00, 8'h01, 8'h05, 8'h00, 18'h14123};
        vecs[4]  = '{1, 16'hFFFD, 8'h07, 16'h0200, 0,  1, 22'h00200, 0, 0, 15'h0200, 8'h07, 8'h01, 8'h05, 8'h00, 18'h00200};
        vecs[5]  = '{0, 16'h0000, 8'h00, 16'h0500, 0,  1, 22'h1C500, 0, 0, 15'h0500, 8'h07, 8'h01, 8'h05, 8'h00, 18'h1C500};
        vecs[6]  = '{0, 16'h0000, 8'h00, 16'h03FF, 0,  1, 22'h003FF, 0, 0, 15'h03FF, 8'h07, 8'h01, 8'h05, 8'h00, 18'h003FF};
        vecs[7]  = '{0, 16'h0000, 8'h00, 16'h0400, 0,  1, 22'h1C400, 0, 0, 15'h0400, 8'h07, 8'h01, 8'h05, 8'h00, 18'h1C400};
        vecs[8]  = '{1, 16'hFFFE, 8'h13, 16'h4010, 0,  1, 22'h4C010, 0, 0, 15'h0010, 8'h07, 8'h13, 8'h05, 8'h00, 18'h0C010};
        vecs[9]  = '{1, 16'hFFFE, 8'hFF, 16'h7FFF, 0,  1, 22'h3FFFFF, 0, 0, 15'h3FFF, 8'h07, 8'hFF, 8'h05, 8'h00, 18'h3FFFF};
        vecs[10] = '{1, 16'h1234, 8'h55, 16'h4000, 0,  1, 22'h3FC000, 0, 0, 15'h0000, 8'h07, 8'hFF, 8'h05, 8'h00, 18'h3C000};
        vecs[11] = '{1, 16'hFFFC, 8'h0C, 16'h9ABC, 0,  0, 22'h15ABC, 1, 0, 15'h5ABC, 8'h07, 8'hFF, 8'h05, 8'h0C, 18'h15ABC};
        vecs[12] = '{0, 16'h0000, 8'h00, 16'h9ABC, 1,  0, 22'h15ABC, 1, 1, 15'h5ABC, 8'h07, 8'hFF, 8'h05, 8'h0C, 18'h15ABC};
        vecs[13] = '{1, 16'h8000, 8'h44, 16'h8000, 0,  0, 22'h14000, 1, 0, 15'h4000, 8'h07, 8'hFF, 8'h05, 8'h0C, 18'h14000};
        vecs[14] = '{0, 16'h0000, 8'h00, 16'hBFFF, 0,  0, 22'h17FFF, 1, 0, 15'h7FFF, 8'h07, 8'hFF, 8'h05, 8'h0C, 18'h17FFF};
        vecs[15] = '{0, 16'h0000, 8'h00, 16'hC000, 0,  0, 22'h00000, 0, 0, 15'h4000, 8'h07, 8'hFF, 8'h05, 8'h0C, 18'h00000};

        rst = 1'b1; mode = 1'b0; wr = 1'b0; addr = 16'h0000; di = 8'h00;
        do_reset(1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            if (v.w) z80_write(v.waddr, v.wdata, 2);
            addr = v.raddr;
            wr   = v.rwr;
            e = '{$sformatf("vec%0d", i), v.rom, v.flash, v.cram, v.cwe, v.caddr,
                  v.p0, v.p1, v.p2, v.ctl, v.flash4, (v.raddr < 16'hC000)};
            sb.push_back(e);
            @(negedge clk);
            compare_next();
            tick();
        end

        // Long Sega strobe with data changing mid-strobe: exactly one update, at the first edge.
        do_reset(1'b0, 1'b0);
        tick();
        addr = 16'hFFFF; di = 8'h05; wr = 1'b1;
        @(negedge clk);
        chk("seq_long_pre_edge_page2", 32'(page2), 32'h02);
        tick();
        chk("seq_long_edge_page2", 32'(page2), 32'h05);
        di = 8'hAA;
        repeat (3) tick();
        chk("seq_long_once_page2", 32'(page2), 32'h05);
        wr = 1'b0; addr = 16'h8123;
        tick();
        chk("seq_long_flash", 32'(flash_addr), 32'h14123);

        // Reset asserted on the same cycle as a write edge suppresses it.
        z80_write(16'hFFFD, 8'h09, 2);
        chk("seq_mid_pre_page0", 32'(page0), 32'h09);
        addr = 16'hFFFF; di = 8'h99;
        rst = 1'b1; wr = 1'b1;
        tick();
        chk("seq_mid_rst_page2", 32'(page2), 32'h02);
        chk("seq_mid_rst_page0", 32'(page0), 32'h00);
        rst = 1'b0;
        repeat (2) tick();
        chk("seq_mid_held_page2", 32'(page2), 32'h02);
        wr = 1'b0;
        tick();

        // Codemasters mode, with wr held high across reset release.
        addr = 16'h8000; di = 8'h33;
        do_reset(1'b1, 1'b1);
        repeat (2) tick();
        chk("seq_cm_hold_page2", 32'(page2), 32'h02);
        wr = 1'b0;
        tick();
        addr = 16'h0100;
        #1;
        chk("seq_cm_low_flash", 32'(flash_addr), 32'h00100);
        addr = 16'h8000; di = 8'h09; wr = 1'b1;
        @(negedge clk);
        chk("seq_cm_old_page_flash", 32'(flash_addr), 32'h08000);
        tick();
        chk("seq_cm_new_page_flash", 32'(flash_addr), 32'h24000);
        chk("seq_cm_page2", 32'(page2), 32'h09);
        wr = 1'b0;
        mode = 1'b0;
        z80_write(16'hFFFF, 8'h77, 2);
        chk("seq_cm_ffff_ignored", 32'(page2), 32'h09);
        z80_write(16'hFFFC, 8'h0C, 2);
        chk("seq_cm_ctrl_zero", 32'(ctrl), 32'h00);
        addr = 16'h9ABC;
        #1;
        chk("seq_cm_cram_sel", 32'(cram_sel), 32'd0);
        chk("seq_cm_rom_sel", 32'(rom_sel), 32'd1);
        chk("seq_cm_slot2_flash", 32'(flash_addr), 32'h25ABC);
        z80_write(16'h0000, 8'h03, 2);
        addr = 16'h0100;
        #1;
        chk("seq_cm_page0_flash", 32'(flash_addr), 32'h0C100);
        z80_write(16'h4000, 8'h21, 2);
        addr = 16'h4010;
        #1;
        chk("seq_cm_page1_flash", 32'(flash_addr), 32'h84010);
        chk("seq_cm_page1_flash4", 32'(flash_addr4), 32'h04010);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
